// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional start-handshake timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 tx_start,
   output logic [7:0]           data_in,
   input  logic                 tx_busy,
   output logic [2:0]           grant_id,
   output logic [15:0]          frame_cnt,
   output logic                 timeout_err
);

   // state   | meaning
   // S_IDLE  | waiting for a request with the UART idle
   // S_START | tx_start held, waiting for tx_busy to rise
   // S_BUSY  | frame in flight, waiting for tx_busy to fall
   typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

   localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

   state_t               state;
   logic [2:0]           win_id;
   logic [7:0]           win_byte;
   logic                 win_valid;
   int                   idx;
   logic [NUM_REQ-1:0]   req_rot;
   logic [NUM_REQ*8-1:0] data_rot;

   // Search starts one past the last winner, so the previous grantee is checked last.
   always_comb begin
      win_id    = '0;
      win_byte  = '0;
      win_valid = 1'b0;
      idx       = 0;
      req_rot   = '0;
      data_rot  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx      = (int'(grant_id) + 1 + k) % NUM_REQ;
         req_rot  = req >> idx;
         data_rot = req_data >> (8 * idx);
         if (!win_valid && req_rot[0]) begin
            win_valid = 1'b1;
            win_id    = 3'(idx);
            win_byte  = data_rot[7:0];
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         grant     <= '0;
         tx_start  <= 1'b0;
         data_in   <= '0;
         grant_id  <= 3'(NUM_REQ - 1);
         frame_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         to_cnt      <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         grant <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               // tx_busy still high means the UART is finishing an older frame.
               if (win_valid && !tx_busy) begin
                  grant    <= GRANT_ONE << win_id;
                  data_in  <= win_byte;
                  grant_id <= win_id;
                  tx_start <= 1'b1;
                  state    <= S_START;
`ifdef UART_ARB_TIMEOUT_EN
                  to_cnt   <= '0;
`endif
               end
            end
            S_START: begin
               if (tx_busy) begin
                  tx_start  <= 1'b0;
                  frame_cnt <= frame_cnt + 16'd1;
                  state     <= S_BUSY;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  tx_start    <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            S_BUSY: begin
               if (!tx_busy) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef UART_ARB_TIMEOUT_EN
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART responder.
// Timeout checks are compiled in when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic        tx_start;
   logic [7:0]  data_in;
   logic        tx_busy;
   logic [2:0]  grant_id;
   logic [15:0] frame_cnt;
   logic        timeout_err;
   logic        uart_auto;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {int id; logic [7:0] b;} exp_t;
   exp_t       exp_q[$];
   logic [7:0] exp_uart[$];

   uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
      .tx_start(tx_start), .data_in(data_in), .tx_busy(tx_busy), .grant_id(grant_id),
      .frame_cnt(frame_cnt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_grant(input int id, input logic [7:0] b);
      exp_t e;
      e.id = id;
      e.b  = b;
      exp_q.push_back(e);
   endtask

   task automatic set_byte(input int i, input logic [7:0] b);
      req_data[8*i +: 8] = b;
   endtask

   task automatic wait_grant(input int exp_id);
      int id = -1;
      for (int i = 0; i < 200 && id < 0; i++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) if (grant[j]) id = j;
      end
      check("wait_grant_id", id, exp_id);
   endtask

   task automatic wait_quiet();
      int q = 0;
      for (int i = 0; i < 300 && q < 3; i++) begin
         @(negedge clk);
         if (!tx_start && !tx_busy && grant == 4'b0) q++;
         else q = 0;
      end
      check("quiet_reached", q, 3);
   endtask

   // Grant monitor: every grant pulse is matched against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && grant !== 4'b0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_grant", grant, 0);
            end else begin
               e = exp_q.pop_front();
               check("grant", grant, 32'(1) << e.id);
               check("data_in", data_in, e.b);
               check("grant_id", grant_id, e.id);
               check("tx_start_at_grant", tx_start, 1);
               check("busy_at_grant", tx_busy, 0);
               if (uart_auto) exp_uart.push_back(e.b);
            end
         end
      end
   end

   // UART responder: raises tx_busy two cycles after tx_start, holds it six cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (uart_auto && !reset && tx_start) begin
            repeat (2) @(negedge clk);
            if (!reset) begin
               check("start_held", tx_start, 1);
               if (exp_uart.size() == 0) check("unexpected_frame", data_in, 0);
               else check("uart_byte", data_in, exp_uart.pop_front());
               tx_busy = 1'b1;
               for (int i = 0; i < 6 && !reset; i++) @(negedge clk);
               tx_busy = 1'b0;
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      exp_uart.delete();
   endtask

   initial begin
      reset     = 1'b1;
      req       = '0;
      req_data  = '0;
      uart_auto = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_data_in", data_in, 0);
      check("rst_grant_id", grant_id, 3);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_timeout_err", timeout_err, 0);
      reset = 1'b0;

      // single request
      expect_grant(0, 8'hDD);
      set_byte(0, 8'hDD);
      req = 4'b0001;
      wait_grant(0);
      req = 4'b0000;
      wait_quiet();
      check("single_frame_cnt", frame_cnt, 1);

      // all four requesting, held across five grants
      do_reset();
      req_data = 32'h4433_2211;
      expect_grant(0, 8'h11);
      expect_grant(1, 8'h22);
      expect_grant(2, 8'h33);
      expect_grant(3, 8'h44);
      expect_grant(0, 8'h11);
      req = 4'b1111;
      wait_grant(0);
      wait_grant(1);
      wait_grant(2);
      wait_grant(3);
      wait_grant(0);
      check("four_frames_cnt", frame_cnt, 4);
      req = 4'b0000;
      wait_quiet();
      check("all_frame_cnt", frame_cnt, 5);

      // fairness: make requester 2 the last winner, then 0 and 2 request together
      set_byte(0, 8'hA5);
      set_byte(2, 8'h5A);
      expect_grant(2, 8'h5A);
      req = 4'b0100;
      wait_grant(2);
      req = 4'b0000;
      wait_quiet();
      expect_grant(0, 8'hA5);
      expect_grant(2, 8'h5A);
      req = 4'b0101;
      wait_grant(0);
      req = 4'b0100;
      wait_grant(2);
      req = 4'b0000;
      wait_quiet();
      check("fair_frame_cnt", frame_cnt, 8);

      // late request: a pulse that drops during BUSY is skipped, a held one waits
      set_byte(3, 8'h44);
      expect_grant(3, 8'h44);
      req = 4'b1000;
      wait_grant(3);
      req = 4'b0000;
      repeat (2) @(negedge clk);
      set_byte(1, 8'h99);
      req = 4'b0010;
      repeat (2) @(negedge clk);
      req = 4'b0000;
      wait_quiet();
      set_byte(0, 8'h66);
      expect_grant(0, 8'h66);
      expect_grant(1, 8'h77);
      req = 4'b0001;
      wait_grant(0);
      req = 4'b0000;
      repeat (4) @(negedge clk);
      set_byte(1, 8'h77);
      req = 4'b0010;
      wait_grant(1);
      req = 4'b0000;
      wait_quiet();
      check("late_frame_cnt", frame_cnt, 11);

      // reset while in BUSY
      set_byte(2, 8'h3C);
      expect_grant(2, 8'h3C);
      req = 4'b0100;
      wait_grant(2);
      req = 4'b0000;
      begin
         int seen = 0;
         for (int i = 0; i < 50 && seen == 0; i++) begin
            @(negedge clk);
            if (tx_busy && !tx_start) seen = 1;
         end
         check("reached_busy", seen, 1);
      end
      reset = 1'b1;
      #1;
      check("midrst_tx_start", tx_start, 0);
      check("midrst_grant", grant, 0);
      check("midrst_frame_cnt", frame_cnt, 0);
      check("midrst_grant_id", grant_id, 3);
      check("midrst_data_in", data_in, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      exp_uart.delete();
      set_byte(0, 8'h10);
      set_byte(1, 8'h20);
      expect_grant(0, 8'h10);
      expect_grant(1, 8'h20);
      req = 4'b0011;
      wait_grant(0);
      req = 4'b0010;
      wait_grant(1);
      req = 4'b0000;
      wait_quiet();
      check("post_rst_frame_cnt", frame_cnt, 2);

`ifdef UART_ARB_TIMEOUT_EN
      uart_auto = 1'b0;
      set_byte(0, 8'hEE);
      expect_grant(0, 8'hEE);
      req = 4'b0001;
      wait_grant(0);
      req = 4'b0000;
      begin
         int k = 0;
         for (int i = 1; i <= 40 && k == 0; i++) begin
            @(negedge clk);
            if (timeout_err) k = i;
         end
         check("timeout_latency", k, 16);
         check("timeout_tx_start", tx_start, 0);
         check("timeout_frame_cnt", frame_cnt, 2);
         @(negedge clk);
         check("timeout_pulse_len", timeout_err, 0);
      end
      wait_quiet();
      check("timeout_grant_id", grant_id, 0);
      uart_auto = 1'b1;
      set_byte(1, 8'hAB);
      expect_grant(1, 8'hAB);
      req = 4'b0011;
      wait_grant(1);
      req = 4'b0000;
      wait_quiet();
      check("after_timeout_frame_cnt", frame_cnt, 3);
`else
      check("timeout_err_tied", timeout_err, 0);
`endif

      check("leftover_grants", exp_q.size(), 0);
      check("leftover_frames", exp_uart.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart` transmitter among `NUM_REQ` byte producers. It sits between the producers and the `uart` block's `tx_start`/`data_in`/`tx_busy` pins. It captures one byte per grant, drives the start handshake, and waits for the frame to finish before re-arbitrating. It also keeps a wrap-around count of frames handed to the UART.

## Interface

- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1024: clock cycles to wait for `tx_busy` to rise after start. Used only with `UART_ARB_TIMEOUT_EN`.

- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  level request per requester. Held with valid data until the matching `grant` pulse.
- `req_data`  in  NUM_REQ*8  byte per requester; requester i owns bits [8i+7:8i].
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse: the byte from requester i is captured.
- `tx_start`  out  1  connects to `uart` `tx_start`.
- `data_in`  out  8  connects to `uart` `data_in`; holds the captured byte.
- `tx_busy`  in  1  from `uart` `tx_busy`.
- `grant_id`  out  3  index of the last granted requester.
- `frame_cnt`  out  16  number of frames accepted by the UART; wraps from 0xFFFF to 0.
- `timeout_err`  out  1  one-cycle pulse when the start handshake times out.

## Operation

The state machine has three states: IDLE, START and BUSY. Reset places it in IDLE.

**IDLE**
- If `req` is non-zero, pick the winner by round-robin. The search starts at `(grant_id+1) mod NUM_REQ` and takes the first set bit.
- On that edge:
  - latch the winner's byte into `data_in`;
  - update `grant_id`;
  - assert `grant[winner]` for exactly one cycle;
  - assert `tx_start`;
  - go to START.
- If `req` is zero, stay in IDLE.

**START**
- Hold `tx_start=1` and keep `data_in` stable.
- When `tx_busy=1` is sampled:
  - `tx_start` goes to 0;
  - `frame_cnt` increments;
  - go to BUSY.

**BUSY**
- `tx_start=0`.
- When `tx_busy=0` is sampled, go to IDLE.

**General rules**
- Requests that arrive during START or BUSY are not granted until the machine returns to IDLE.
- A requester that drops `req` before its grant is simply skipped.
- When several requests are pending at once, round-robin guarantees each requester is granted within `NUM_REQ` grants.
- `tx_busy` high while in IDLE (UART still finishing an earlier frame) blocks arbitration. No grant is issued until `tx_busy=0`.

## Timing

- **Reset values:** `grant=0`, `tx_start=0`, `data_in=0`, `grant_id=NUM_REQ-1` (so requester 0 wins first), `frame_cnt=0`, `timeout_err=0`, state IDLE.
- **Reset mid-frame:** all outputs return to their reset values immediately (asynchronously). The UART is reset by the same `reset`.
- **Request to start:** `req` sampled at edge k in IDLE gives `grant` and `tx_start` high during cycle k+1, with `data_in` valid in that same cycle.
- **Release of start:** `tx_start` falls on the edge after `tx_busy` is first sampled high.
- **Back-to-back frames:** minimum one IDLE cycle between `tx_busy` falling and the next `tx_start`.
- **Output drive:** all outputs are registered.

## Configuration

- **`UART_ARB_TIMEOUT_EN` defined:**
  - A counter, cleared on entry to START, counts START cycles.
  - If it reaches `TIMEOUT_CYCLES` without `tx_busy=1`: drop `tx_start`, pulse `timeout_err` for one cycle, return to IDLE.
  - `frame_cnt` is not incremented.
  - `grant_id` keeps the timed-out requester, so round-robin continues past it.
- **`UART_ARB_TIMEOUT_EN` not defined:**
  - START waits indefinitely.
  - `timeout_err` is tied to 0 and no counter logic is present.
  - The port list is identical in both builds.

## Test plan

- **Single request:** reset, then `req=4'b0001`, `req_data[7:0]=8'hDD`.
  - Required: `grant=0001` for one cycle, `data_in=8'hDD`, `tx_start` high until `tx_busy` rises.
  - After the UART reports `data_out=8'hDD` with `op_valid`, `frame_cnt=1`.
- **All four requesting:** `req=4'b1111` held throughout, bytes 0x11/0x22/0x33/0x44.
  - Required: grants in order 0,1,2,3,0.
  - UART outputs 0x11, 0x22, 0x33, 0x44 in order; `frame_cnt=4` after four frames.
- **Fairness:** `grant_id=2`, then `req=4'b0101`.
  - Required: requester 0 wins first, then requester 2.
- **Reset mid-frame:** assert `reset` while in BUSY.
  - Required: `tx_start=0`, `grant=0`, `frame_cnt=0` immediately.
  - After release, the next grant goes to requester 0.
- **Timeout (with `UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`):** hold `tx_busy=0` after a grant.
  - Required: `timeout_err` pulses 16 cycles after `tx_start` rises, `tx_start=0` in the same cycle, `frame_cnt` unchanged.
- **Late request:** `req` drops before grant, then re-asserts during BUSY.
  - Required: no grant until IDLE; then granted exactly once.
